// File: rtl/phase_align.sv
// -----------------------------------------------------------------------------
// phase_align
//
// Searches the four receiver downsampling phases and DELAY_MAX reference delays
// for the combination where the recovered bit stream (dx) best matches the
// delayed PRBS reference (sx). It then locks onto that combination and keeps
// monitoring the error rate. Lock is dropped when a window exceeds LOSS_THR.
//
// Search sequence, repeated for phase 0..3:
//   SETTLE (SETTLE enabled symbols, nothing counted)
//   MEASURE (WINDOW enabled symbols, one error counter per delay)
//   EVAL (DELAY_MAX scan clocks plus one decision clock)
// The running minimum is carried across all four phases. After phase 3 the
// block settles once more at the best phase and then enters LOCKED.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset; search restarts on release
//   enable      symbol strobe; sx/dx sampled only when high
//   sx          reference PRBS bit
//   dx          recovered bit from the receiver
//   start       one-cycle pulse, restarts the search from any state
//   phase_out   downsampling phase for the receiver (registered)
//   best_delay  selected reference delay (registered)
//   lock        high while aligned (registered)
//   err_count   errors in the last completed window (registered)
//   o_dbg_state current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module phase_align #(
  parameter int WINDOW    = 1024,
  parameter int DELAY_MAX = 32,
  parameter int SETTLE    = 64,
  parameter int LOSS_THR  = WINDOW / 8,
  localparam int DW = $clog2(DELAY_MAX),
  localparam int CW = $clog2(WINDOW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          sx,
  input  logic          dx,
  input  logic          start,
  output logic [1:0]    phase_out,
  output logic [DW-1:0] best_delay,
  output logic          lock,
  output logic [CW-1:0] err_count,
  output logic [2:0]    o_dbg_state
);

  localparam int SW = $clog2((WINDOW > SETTLE) ? WINDOW : SETTLE) + 1;
  localparam int EW = $clog2(DELAY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_EVAL    = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t              r_state;
  logic [DELAY_MAX-2:0] r_sr;
  logic [CW-1:0]       r_cnt [DELAY_MAX];
  logic [SW-1:0]       r_sym_cnt;
  logic [EW-1:0]       r_eval_idx;
  logic [CW-1:0]       r_min_cnt;
  logic [1:0]          r_min_phase;
  logic [DW-1:0]       r_min_delay;
  logic                r_lock_pend;
  logic [CW-1:0]       r_err_cnt;
  logic [1:0]          r_phase_out;
  logic [DW-1:0]       r_best_delay;
  logic                r_lock;
  logic [CW-1:0]       r_err_out;

  // Tap d is sx delayed by d enabled symbols; tap 0 is the current sx.
  logic [DELAY_MAX-1:0] w_taps;
  logic                 w_miss;
  logic [CW-1:0]        w_err_next;

  assign w_taps     = {r_sr, sx};
  assign w_miss     = w_taps[r_best_delay] ^ dx;
  assign w_err_next = r_err_cnt + {{(CW-1){1'b0}}, w_miss};

  // Reference delay line, advances only on enabled symbols in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (enable) begin
      r_sr <= w_taps[DELAY_MAX-2:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      for (int d = 0; d < DELAY_MAX; d++) r_cnt[d] <= '0;
      r_sym_cnt    <= '0;
      r_eval_idx   <= '0;
      r_min_cnt    <= '1;
      r_min_phase  <= '0;
      r_min_delay  <= '0;
      r_lock_pend  <= 1'b0;
      r_err_cnt    <= '0;
      r_phase_out  <= '0;
      r_best_delay <= '0;
      r_lock       <= 1'b0;
      r_err_out    <= '0;
    end else if (start) begin
      // Remaining cleanup happens in IDLE on the following clock.
      r_state     <= S_IDLE;
      r_lock      <= 1'b0;
      r_phase_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_phase_out <= '0;
          for (int d = 0; d < DELAY_MAX; d++) r_cnt[d] <= '0;
          r_sym_cnt   <= '0;
          r_eval_idx  <= '0;
          // All-ones exceeds WINDOW, so the first scanned counter always wins.
          r_min_cnt   <= '1;
          r_min_phase <= '0;
          r_min_delay <= '0;
          r_lock_pend <= 1'b0;
          r_err_cnt   <= '0;
          r_state     <= S_SETTLE;
        end

        S_SETTLE: begin
          if (enable) begin
            if (r_sym_cnt == SW'(SETTLE - 1)) begin
              r_sym_cnt <= '0;
              r_err_cnt <= '0;
              r_state   <= r_lock_pend ? S_LOCKED : S_MEASURE;
            end else begin
              r_sym_cnt <= r_sym_cnt + 1'b1;
            end
          end
        end

        S_MEASURE: begin
          if (enable) begin
            for (int d = 0; d < DELAY_MAX; d++) begin
              if (w_taps[d] != dx) r_cnt[d] <= r_cnt[d] + 1'b1;
            end
            if (r_sym_cnt == SW'(WINDOW - 1)) begin
              r_sym_cnt  <= '0;
              r_eval_idx <= '0;
              r_state    <= S_EVAL;
            end else begin
              r_sym_cnt <= r_sym_cnt + 1'b1;
            end
          end
        end

        S_EVAL: begin
          if (r_eval_idx == EW'(DELAY_MAX)) begin
            // Decision clock: the minimum from the last scan step is now valid.
            r_eval_idx <= '0;
            for (int d = 0; d < DELAY_MAX; d++) r_cnt[d] <= '0;
            if (r_phase_out == 2'd3) begin
              r_phase_out  <= r_min_phase;
              r_best_delay <= r_min_delay;
              r_lock       <= 1'b1;
              r_err_out    <= r_min_cnt;
              r_lock_pend  <= 1'b1;
            end else begin
              r_phase_out <= r_phase_out + 1'b1;
            end
            r_state <= S_SETTLE;
          end else begin
            // Strict less-than keeps the earliest phase/delay on ties.
            if (r_cnt[r_eval_idx[DW-1:0]] < r_min_cnt) begin
              r_min_cnt   <= r_cnt[r_eval_idx[DW-1:0]];
              r_min_phase <= r_phase_out;
              r_min_delay <= r_eval_idx[DW-1:0];
            end
            r_eval_idx <= r_eval_idx + 1'b1;
          end
        end

        S_LOCKED: begin
          if (enable) begin
            if (r_sym_cnt == SW'(WINDOW - 1)) begin
              r_sym_cnt <= '0;
              r_err_cnt <= '0;
              r_err_out <= w_err_next;
              if (w_err_next > CW'(LOSS_THR)) begin
                r_lock      <= 1'b0;
                r_phase_out <= '0;
                r_state     <= S_IDLE;
              end
            end else begin
              r_err_cnt <= w_err_next;
              r_sym_cnt <= r_sym_cnt + 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign phase_out   = r_phase_out;
  assign best_delay  = r_best_delay;
  assign lock        = r_lock;
  assign err_count   = r_err_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_phase_align.sv
// -----------------------------------------------------------------------------
// tb_phase_align
//
// Bench for phase_align with default parameters. A receiver model turns the
// DUT's phase_out into dx. Each phase is configured as one of:
//   - random bits (no alignment possible);
//   - sx delayed by a chosen number of enabled symbols, error-free;
//   - the same, with one bit flip every N enabled symbols.
// A flip every N symbols gives exactly WINDOW/N errors in any window of WINDOW
// enabled symbols, whatever the window alignment. This makes the expected
// search result and the locked-window error count plain arithmetic.
// -----------------------------------------------------------------------------
module tb_phase_align;

  localparam int W       = 1024;
  localparam int D       = 32;
  localparam int S       = 64;
  localparam int LAT     = 1 + 4 * (S + W) + 4 * (D + 1);
  localparam int TIMEOUT = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sx;
  logic        dx;
  logic        start;
  logic [1:0]  phase_out;
  logic [4:0]  best_delay;
  logic        lock;
  logic [10:0] err_count;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  // Receiver model configuration per phase: cfg_per -1 = random dx,
  // 0 = error-free at cfg_delay, N>0 = flip every N-th enabled symbol.
  int cfg_delay [4];
  int cfg_per   [4];
  int per_tab   [6] = '{0, 8, 16, 32, 64, 128};
  int sym_idx   = 0;
  int inj_lo    = 0;
  int inj_hi    = 0;
  int lock_base = 0;
  bit hist [$];

  phase_align dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sx         (sx),
    .dx         (dx),
    .start      (start),
    .phase_out  (phase_out),
    .best_delay (best_delay),
    .lock       (lock),
    .err_count  (err_count),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_hist();
    hist = {};
    repeat (64) hist.push_front(1'b0);
  endtask

  // Called at a negedge. Drives one clock of stimulus and returns at the next
  // negedge, where outputs are sampled.
  task automatic drive(input bit en, input bit st);
    bit s;
    bit d;
    int p;
    s = 1'($urandom_range(0, 1));
    p = int'(phase_out);
    if (en) begin
      hist.push_front(s);
      if (hist.size() > 64) void'(hist.pop_back());
    end
    if (!en || cfg_per[p] < 0) begin
      d = 1'($urandom_range(0, 1));
    end else begin
      d = hist[cfg_delay[p]];
      if (cfg_per[p] > 0 && (sym_idx % cfg_per[p]) == 0) d = ~d;
    end
    if (en && sym_idx >= inj_lo && sym_idx < inj_hi) d = ~d;
    enable = en;
    sx     = s;
    dx     = d;
    start  = st;
    if (en) sym_idx++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic bit rnd_en(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic run_syms(input int n, input int pct);
    int k;
    int guard;
    bit e;
    k = 0;
    guard = 0;
    while (k < n && guard < TIMEOUT) begin
      e = rnd_en(pct);
      drive(e, 1'b0);
      if (e) k++;
      guard++;
    end
  endtask

  task automatic wait_lock(input int pct, output int lat);
    lat = 0;
    while (lock !== 1'b1 && lat < TIMEOUT) begin
      drive(rnd_en(pct), 1'b0);
      lat++;
    end
    checks++;
    if (lock !== 1'b1) begin
      failures++;
      $display("FAIL lock_timeout: lock=%b after %0d clocks, required 1", lock, lat);
    end
  endtask

  task automatic rand_cfg();
    int fp;
    fp = $urandom_range(0, 3);
    for (int p = 0; p < 4; p++) begin
      cfg_delay[p] = $urandom_range(0, D - 1);
      if (p == fp || $urandom_range(0, 1) == 1) cfg_per[p] = per_tab[$urandom_range(0, 5)];
      else cfg_per[p] = -1;
    end
  endtask

  // Reference: lowest error count wins; ties go to the lower phase. Only
  // aligned phases can approach a low count.
  function automatic void expect_best(output int ph, output int dl, output int cnt);
    int c;
    cnt = W + 1;
    ph  = 0;
    dl  = 0;
    for (int p = 0; p < 4; p++) begin
      if (cfg_per[p] >= 0) begin
        c = (cfg_per[p] == 0) ? 0 : W / cfg_per[p];
        if (c < cnt) begin
          cnt = c;
          ph  = p;
          dl  = cfg_delay[p];
        end
      end
    end
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (phase_out !== 2'd0) begin failures++; $display("FAIL reset_phase: got %0d required 0", phase_out); end
    checks++; if (best_delay !== 5'd0) begin failures++; $display("FAIL reset_delay: got %0d required 0", best_delay); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL reset_lock: got %b required 0", lock); end
    checks++; if (err_count !== 11'd0) begin failures++; $display("FAIL reset_err: got %0d required 0", err_count); end
  endtask

  task automatic test_basic_search();
    int lat;
    cfg_per   = '{-1, -1, 0, -1};
    cfg_delay = '{0, 0, 7, 0};
    wait_lock(100, lat);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
    checks++; if (phase_out !== 2'd2) begin failures++; $display("FAIL basic_phase: got %0d required 2", phase_out); end
    checks++; if (best_delay !== 5'd7) begin failures++; $display("FAIL basic_delay: got %0d required 7", best_delay); end
    checks++; if (err_count !== 11'd0) begin failures++; $display("FAIL basic_err: got %0d required 0", err_count); end
    lock_base = sym_idx;
  endtask

  task automatic test_errors_below_thr();
    inj_lo = lock_base + S + 100;
    inj_hi = inj_lo + 100;
    run_syms(S + W, 100);
    checks++; if (err_count !== 11'd100) begin failures++; $display("FAIL below_thr_err: got %0d required 100", err_count); end
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL below_thr_lock: got %b required 1", lock); end
  endtask

  task automatic test_errors_loss();
    inj_lo = lock_base + S + W + 300;
    inj_hi = inj_lo + 200;
    run_syms(W - 1, 100);
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL loss_early: lock=%b before window end, required 1", lock); end
    run_syms(1, 100);
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL loss_lock: got %b required 0", lock); end
    checks++; if (err_count !== 11'd200) begin failures++; $display("FAIL loss_err: got %0d required 200", err_count); end
    checks++; if (phase_out !== 2'd0) begin failures++; $display("FAIL loss_phase: got %0d required 0", phase_out); end
    inj_lo = 0;
    inj_hi = 0;
  endtask

  task automatic test_tie();
    int lat;
    cfg_per   = '{-1, 0, 0, -1};
    cfg_delay = '{0, 5, 5, 0};
    drive(1'b1, 1'b1);
    wait_lock(100, lat);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL tie_latency: got %0d required %0d", lat, LAT); end
    checks++; if (phase_out !== 2'd1) begin failures++; $display("FAIL tie_phase: got %0d required 1", phase_out); end
    checks++; if (best_delay !== 5'd5) begin failures++; $display("FAIL tie_delay: got %0d required 5", best_delay); end
    checks++; if (err_count !== 11'd0) begin failures++; $display("FAIL tie_err: got %0d required 0", err_count); end
  endtask

  // Entered while locked at phase 1 / delay 5.
  task automatic test_rst_in_eval();
    drive(1'b1, 1'b1);
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL start_lock: got %b required 0", lock); end
    checks++; if (phase_out !== 2'd0) begin failures++; $display("FAIL start_phase: got %0d required 0", phase_out); end
    // IDLE clock, phase 0 (settle+measure+eval+decision), then into phase 1 eval.
    repeat (1 + (S + W) + (D + 1) + (S + W) + 5) drive(1'b1, 1'b0);
    checks++; if (phase_out !== 2'd1) begin failures++; $display("FAIL eval_phase: got %0d required 1", phase_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (phase_out !== 2'd0) begin failures++; $display("FAIL async_rst_phase: got %0d required 0", phase_out); end
    checks++; if (best_delay !== 5'd0) begin failures++; $display("FAIL async_rst_delay: got %0d required 0", best_delay); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL async_rst_lock: got %b required 0", lock); end
    checks++; if (err_count !== 11'd0) begin failures++; $display("FAIL async_rst_err: got %0d required 0", err_count); end
    enable = 1'b0;
    clear_hist();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs straight after reset release: search must start on its own.
  task automatic test_enable_freeze();
    int lat;
    int l2;
    int tp;
    tp = $urandom_range(0, 3);
    cfg_per   = '{-1, -1, -1, -1};
    cfg_per[tp]   = 64;
    cfg_delay[tp] = $urandom_range(0, D - 1);
    lat = 0;
    repeat (1 + S + 100) begin drive(1'b1, 1'b0); lat++; end
    repeat (500) begin drive(1'b0, 1'b0); lat++; end
    wait_lock(100, l2);
    lat += l2;
    checks++; if (lat !== LAT + 500) begin failures++; $display("FAIL freeze_latency: got %0d required %0d", lat, LAT + 500); end
    checks++; if (phase_out !== 2'(tp)) begin failures++; $display("FAIL freeze_phase: got %0d required %0d", phase_out, tp); end
    checks++; if (best_delay !== 5'(cfg_delay[tp])) begin failures++; $display("FAIL freeze_delay: got %0d required %0d", best_delay, cfg_delay[tp]); end
    checks++; if (err_count !== 11'd16) begin failures++; $display("FAIL freeze_err: got %0d required 16", err_count); end
  endtask

  task automatic test_start_mid_measure();
    int lat;
    int guard;
    int ph;
    int dl;
    int cnt;
    drive(1'b1, 1'b1);
    guard = 0;
    while (phase_out !== 2'd1 && guard < TIMEOUT) begin drive(1'b1, 1'b0); guard++; end
    run_syms(S + 100, 100);
    checks++; if (phase_out !== 2'd1) begin failures++; $display("FAIL mid_meas_phase: got %0d required 1", phase_out); end
    rand_cfg();
    drive(1'b1, 1'b1);
    checks++; if (phase_out !== 2'd0) begin failures++; $display("FAIL mid_start_phase: got %0d required 0", phase_out); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL mid_start_lock: got %b required 0", lock); end
    wait_lock(100, lat);
    expect_best(ph, dl, cnt);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL mid_latency: got %0d required %0d", lat, LAT); end
    checks++; if (phase_out !== 2'(ph)) begin failures++; $display("FAIL mid_phase: got %0d required %0d", phase_out, ph); end
    checks++; if (best_delay !== 5'(dl)) begin failures++; $display("FAIL mid_delay: got %0d required %0d", best_delay, dl); end
    checks++; if (err_count !== 11'(cnt)) begin failures++; $display("FAIL mid_err: got %0d required %0d", err_count, cnt); end
  endtask

  task automatic test_random();
    int lat;
    int pct;
    int ph;
    int dl;
    int cnt;
    for (int t = 0; t < 3; t++) begin
      pct = (t == 1) ? 70 : 100;
      rand_cfg();
      expect_best(ph, dl, cnt);
      drive(rnd_en(pct), 1'b1);
      wait_lock(pct, lat);
      if (pct == 100) begin
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rand%0d_latency: got %0d required %0d", t, lat, LAT); end
      end
      checks++; if (phase_out !== 2'(ph)) begin failures++; $display("FAIL rand%0d_phase: got %0d required %0d", t, phase_out, ph); end
      checks++; if (best_delay !== 5'(dl)) begin failures++; $display("FAIL rand%0d_delay: got %0d required %0d", t, best_delay, dl); end
      checks++; if (err_count !== 11'(cnt)) begin failures++; $display("FAIL rand%0d_err: got %0d required %0d", t, err_count, cnt); end
      run_syms(S + W, pct);
      checks++; if (err_count !== 11'(cnt)) begin failures++; $display("FAIL rand%0d_locked_err: got %0d required %0d", t, err_count, cnt); end
      checks++; if (lock !== 1'b1) begin failures++; $display("FAIL rand%0d_locked: got %b required 1", t, lock); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    sx     = 1'b0;
    dx     = 1'b0;
    start  = 1'b0;
    cfg_per   = '{-1, -1, -1, -1};
    cfg_delay = '{0, 0, 0, 0};
    clear_hist();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_basic_search();
    test_errors_below_thr();
    test_errors_loss();
    test_tie();
    test_rst_in_eval();
    test_enable_freeze();
    test_start_mid_measure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
